riscv_icache_arb: RTL
=====================

# riscv_icache_arb

Arbiter and sequencer for the shared instruction-cache request port. Two requesters share the port: the fetch unit (requester F, demand) and a next-line prefetcher (requester P). The block does three things: grants at most one new request per cycle, tracks up to `MAX_OUTSTANDING` in-order responses and routes each to its owner, and sequences cache flushes by draining outstanding requests before pulsing `icache_flush_o`. It sits between the fetch stage and the icache.

## Interface
- `MAX_OUTSTANDING`, 2: owner-FIFO depth; legal values 1..4.
- `STARVE_LIMIT`, 4: consecutive F grants, while P is requesting, before P is forced a grant; legal values 1..15.

- `clk_i` in 1: clock. One clock; all logic on rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `f_rd_i` in 1: F request.
- `f_pc_i` in 32: F address.
- `f_priv_i` in 2: F privilege level.
- `f_flush_i` in 1: flush request pulse.
- `f_accept_o` out 1: F request issued this cycle.
- `f_valid_o` out 1: response for F.
- `f_inst_o` out 32: response instruction word for F.
- `f_error_o` out 1: bus error for F.
- `f_page_fault_o` out 1: page fault for F.
- `p_rd_i` in 1: P request.
- `p_pc_i` in 32: P address.
- `p_priv_i` in 2: P privilege level.
- `p_accept_o` out 1: P request issued this cycle.
- `p_valid_o` out 1: response for P; P has no inst/error outputs and its responses are discarded otherwise.
- `icache_rd_o` out 1: cache read request.
- `icache_pc_o` out 32: cache address, bits [1:0] forced to 0.
- `icache_priv_o` out 2: cache privilege level.
- `icache_flush_o` out 1: cache flush pulse.
- `icache_accept_i` in 1: cache took the request.
- `icache_valid_i` in 1: cache response valid.
- `icache_inst_i` in 32: cache response data.
- `icache_error_i` in 1: cache bus error.
- `icache_page_fault_i` in 1: cache page fault.
- `busy_o` out 1: asserted while `state != RUN`.
- `spurious_o` out 1: sticky flag; set when a response arrives with the owner FIFO empty.

## Operation
- State machine: RUN, DRAIN, FLUSH. Reset state is RUN.
  - RUN → DRAIN on `f_flush_i`.
  - DRAIN → FLUSH when the registered outstanding count is 0.
  - FLUSH → RUN unconditionally after one cycle.
- `f_flush_i` seen in DRAIN or FLUSH is coalesced (ignored).
- Issue is allowed only when all of these hold: `state == RUN`, `!f_flush_i`, and `count < MAX_OUTSTANDING`.
- Grant selection (combinational):
  - Default: F has priority when `f_rd_i` is asserted.
  - Override: P wins when `p_rd_i && starve_cnt == STARVE_LIMIT`.
  - Unchosen requester: sees accept = 0.
- Output forwarding:
  - `icache_rd_o` = issue allowed and the chosen requester's rd is asserted.
  - `icache_pc_o` and `icache_priv_o` are muxed from the chosen requester; when idle they show F's values.
- Accept forwarding: `f_accept_o` / `p_accept_o` = `icache_rd_o && icache_accept_i && chosen==F/P`.
- `starve_cnt` (4 bits):
  - Increments when F is accepted while `p_rd_i` is asserted.
  - Clears when P is accepted, or when `p_rd_i` is 0.
  - Saturates at `STARVE_LIMIT`.
- Owner FIFO:
  - 1-bit entries (0 = F, 1 = P); `count` is 0..`MAX_OUTSTANDING`.
  - Push on `icache_rd_o && icache_accept_i`.
  - Pop on `icache_valid_i` when `count != 0`.
  - Push and pop in the same cycle leave `count` unchanged.
  - Read/write pointers wrap modulo `MAX_OUTSTANDING`.
- Response routing:
  - `f_valid_o` = `icache_valid_i && count != 0 && head == F`.
  - `p_valid_o` is the same with `head == P`.
  - `f_inst_o`, `f_error_o`, `f_page_fault_o` pass through directly from the cache.
- `icache_valid_i` with `count == 0`: no routing, no pop; `spurious_o` is set and stays set until reset.
- Reset mid-operation: the FIFO and counters clear, and state returns to RUN. Responses still in flight from the cache then count as spurious.

## Timing
- Reset values: `f_accept_o`, `p_accept_o`, `f_valid_o`, `p_valid_o`, `icache_rd_o`, `icache_flush_o`, `busy_o`, `spurious_o` are all 0. `count`, `starve_cnt` and the FIFO pointers are all 0.
- Request path and response path are both zero-latency combinational.
- Flush latency, with `f_flush_i` at cycle N and `count == 0`:
  - N+1: DRAIN.
  - N+2: FLUSH, with `icache_flush_o = 1` for exactly one cycle.
  - N+3: RUN.
- Flush with requests outstanding: DRAIN holds until a registered `count == 0`. A final pop at cycle M gives FLUSH at M+2.
- No request is issued in the cycle `f_flush_i` is high, nor in any cycle in DRAIN or FLUSH.
- FIFO full (`count == MAX_OUTSTANDING`): `icache_rd_o = 0`. A pop in that cycle does not re-enable issue until the next cycle, because `count` is registered.

## Test plan
- F only, `icache_accept_i = 1`, `f_pc_i = 0x8000_0003`:
  - `icache_pc_o = 0x8000_0000`, `f_accept_o = 1` in the same cycle.
  - A response 1 cycle later with `inst = 0x0000_0013` gives `f_valid_o = 1`, `f_inst_o = 0x13`, `p_valid_o = 0`.
- F and P held high every cycle, always accepted, `STARVE_LIMIT = 4`: grant pattern is F,F,F,F,P repeating; P is accepted on the 5th cycle.
- `MAX_OUTSTANDING = 2`, issue F then P, no responses:
  - Third request gets `icache_rd_o = 0`.
  - Responses arrive in order F then P → `f_valid_o`, then `p_valid_o`.
- `f_flush_i` with 2 outstanding:
  - `busy_o = 1`; no `icache_rd_o` until flush completes.
  - `icache_flush_o` pulses exactly once, 2 cycles after the last response.
  - Then RUN.
- `f_flush_i` pulsed twice during DRAIN: still exactly one `icache_flush_o` pulse.
- `icache_valid_i` with `count = 0`: `spurious_o` rises and stays at 1, no valid output; asserting `rst_i` mid-run clears it along with `count`.

Source files
------------

// File: rtl/riscv_icache_arb_if.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// riscv_icache_arb_if
// Bundles every signal around the shared icache request port:
//   - fetch requester F (request, flush pulse, routed response)
//   - prefetch requester P (request, routed valid)
//   - icache side (request, flush pulse, accept, response)
//   - status (busy, sticky spurious-response flag)
// Modports:
//   slave  : the arbiter itself (riscv_icache_arb)
//   master : the surrounding environment (fetch, prefetcher and cache)
// ---------------------------------------------------------------------------
interface riscv_icache_arb_if;
  // Fetch requester
  logic        f_rd_i;
  logic [31:0] f_pc_i;
  logic [1:0]  f_priv_i;
  logic        f_flush_i;
  logic        f_accept_o;
  logic        f_valid_o;
  logic [31:0] f_inst_o;
  logic        f_error_o;
  logic        f_page_fault_o;
  // Prefetch requester
  logic        p_rd_i;
  logic [31:0] p_pc_i;
  logic [1:0]  p_priv_i;
  logic        p_accept_o;
  logic        p_valid_o;
  // Icache port
  logic        icache_rd_o;
  logic [31:0] icache_pc_o;
  logic [1:0]  icache_priv_o;
  logic        icache_flush_o;
  logic        icache_accept_i;
  logic        icache_valid_i;
  logic [31:0] icache_inst_i;
  logic        icache_error_i;
  logic        icache_page_fault_i;
  // Status
  logic        busy_o;
  logic        spurious_o;

  modport slave (
    input  f_rd_i, f_pc_i, f_priv_i, f_flush_i,
    output f_accept_o, f_valid_o, f_inst_o, f_error_o, f_page_fault_o,
    input  p_rd_i, p_pc_i, p_priv_i,
    output p_accept_o, p_valid_o,
    output icache_rd_o, icache_pc_o, icache_priv_o, icache_flush_o,
    input  icache_accept_i, icache_valid_i, icache_inst_i,
    input  icache_error_i, icache_page_fault_i,
    output busy_o, spurious_o
  );

  modport master (
    output f_rd_i, f_pc_i, f_priv_i, f_flush_i,
    input  f_accept_o, f_valid_o, f_inst_o, f_error_o, f_page_fault_o,
    output p_rd_i, p_pc_i, p_priv_i,
    input  p_accept_o, p_valid_o,
    input  icache_rd_o, icache_pc_o, icache_priv_o, icache_flush_o,
    output icache_accept_i, icache_valid_i, icache_inst_i,
    output icache_error_i, icache_page_fault_i,
    input  busy_o, spurious_o
  );
endinterface

// File: rtl/riscv_icache_arb.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// riscv_icache_arb
// Arbiter and sequencer for the shared instruction-cache request port.
//   - Grants at most one new request per cycle between fetch (F, priority)
//     and the next-line prefetcher (P), forcing a P grant after
//     STARVE_LIMIT consecutive F grants while P waits.
//   - Tracks up to MAX_OUTSTANDING in-order responses in an owner FIFO and
//     routes each response valid to its requester.
//   - Sequences flushes: stop issuing, drain outstanding requests, pulse
//     icache_flush_o for one cycle, resume.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset
//   bus   : riscv_icache_arb_if.slave (requester, icache and status signals)
// Parameters:
//   MAX_OUTSTANDING : owner FIFO depth, 1..4
//   STARVE_LIMIT    : F grants in a row before P is forced, 1..15
// ---------------------------------------------------------------------------
module riscv_icache_arb #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  riscv_icache_arb_if.slave    bus
);

  localparam int CNT_W = 3;
  localparam int PTR_W = 2;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_FLUSH
  } state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [CNT_W-1:0]   r_count;
  logic [PTR_W-1:0]   r_rdPtr;
  logic [PTR_W-1:0]   r_wrPtr;
  // Owner storage is a fixed 4-entry vector so the 2-bit pointers index it
  // cleanly for any depth; entries at or above MAX_OUTSTANDING stay unused.
  logic [3:0]         r_owner;
  logic [3:0]         r_starveCnt;
  logic               r_spurious;

  logic               w_issueOk;
  logic               w_pickP;
  logic               w_icacheRd;
  logic               w_push;
  logic               w_pop;
  logic               w_head;
  logic               w_fAccept;
  logic               w_pAccept;

  // Issue gating and grant selection. F wins by default; P wins when F is
  // idle or when P has been passed over STARVE_LIMIT times in a row.
  // Issue is blocked in the very cycle a flush is requested so that no new
  // request can slip in ahead of the drain.
  always_comb begin
    w_issueOk  = (r_state == ST_RUN) && !bus.f_flush_i &&
                 (r_count < CNT_W'(MAX_OUTSTANDING));
    w_pickP    = bus.p_rd_i &&
                 (!bus.f_rd_i || (r_starveCnt == 4'(STARVE_LIMIT)));
    w_icacheRd = w_issueOk && (bus.f_rd_i || bus.p_rd_i);
    w_push     = w_icacheRd && bus.icache_accept_i;
    w_fAccept  = w_push && !w_pickP;
    w_pAccept  = w_push && w_pickP;
    w_pop      = bus.icache_valid_i && (r_count != '0);
    w_head     = r_owner[r_rdPtr];
  end

  // Request path forwarding; address and privilege follow the chosen
  // requester and show F's values whenever P is not chosen.
  assign bus.icache_rd_o    = w_icacheRd;
  assign bus.icache_pc_o    = w_pickP ? {bus.p_pc_i[31:2], 2'b00}
                                      : {bus.f_pc_i[31:2], 2'b00};
  assign bus.icache_priv_o  = w_pickP ? bus.p_priv_i : bus.f_priv_i;
  assign bus.f_accept_o     = w_fAccept;
  assign bus.p_accept_o     = w_pAccept;

  // Response path routing from the FIFO head; data passes straight through.
  assign bus.f_valid_o      = w_pop && !w_head;
  assign bus.p_valid_o      = w_pop && w_head;
  assign bus.f_inst_o       = bus.icache_inst_i;
  assign bus.f_error_o      = bus.icache_error_i;
  assign bus.f_page_fault_o = bus.icache_page_fault_i;

  assign bus.icache_flush_o = (r_state == ST_FLUSH);
  assign bus.busy_o         = (r_state != ST_RUN);
  assign bus.spurious_o     = r_spurious;

  // Flush sequencer state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Flush sequencer next state. DRAIN looks at the registered count, so the
  // final pop is seen one cycle later; flush requests outside RUN are
  // coalesced into the flush already in progress.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      ST_RUN:   if (bus.f_flush_i) w_nextState = ST_DRAIN;
      ST_DRAIN: if (r_count == '0) w_nextState = ST_FLUSH;
      ST_FLUSH: w_nextState = ST_RUN;
      default:  w_nextState = ST_RUN;
    endcase
  end

  // Owner FIFO: push the winner on an accepted request, pop on a response
  // that has an owner. Pointers wrap at MAX_OUTSTANDING, not at 4.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count <= '0;
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_owner <= '0;
    end else begin
      if (w_push) begin
        r_owner[r_wrPtr] <= w_pickP;
        r_wrPtr <= (r_wrPtr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= (r_rdPtr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : r_rdPtr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Starvation counter: counts F grants that P watched go by, clears as
  // soon as P is served or stops asking, and saturates at the limit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_starveCnt <= '0;
    end else if (!bus.p_rd_i || w_pAccept) begin
      r_starveCnt <= '0;
    end else if (w_fAccept && (r_starveCnt < 4'(STARVE_LIMIT))) begin
      r_starveCnt <= r_starveCnt + 1'b1;
    end
  end

  // Sticky flag for a response that arrives with nobody waiting for it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_spurious <= 1'b0;
    end else if (bus.icache_valid_i && (r_count == '0)) begin
      r_spurious <= 1'b1;
    end
  end

endmodule
